fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the five-stage MIPS pipeline.
- Holds the PC and drives the instruction-memory address.
- Latches the fetched word and its PC into the ID stage.
- Computes the next PC from the 2-bit PC select produced by the ID-stage controller (00 seq, 01 beq, 10 j/jal, 11 jr/jalr). One architectural delay slot; branches and jumps resolve in ID.

Parameters:
- PC_RESET, 32'h0000_3000, PC value after reset and base of the instruction memory.
- IM_AW, 10, instruction-memory word-address width (1024 words).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- stall  input  1  hazard unit: hold PC and IF/ID.
- flush  input  1  clear IF/ID to a bubble.
- pcsel_d  input  2  controller PC select for the instruction in ID.
- br_eq_d  input  1  ID comparator result (rs == rt).
- rs_data_d  input  32  forwarded rs value, jr/jalr target.
- im_addr  output  IM_AW  instruction-memory word address.
- im_rdata  input  32  instruction word, combinational read.
- pc_f  output  32  current fetch PC.
- instr_d  output  32  IF/ID instruction.
- pc_d  output  32  IF/ID PC.
- pc8_d  output  32  pc_d + 8, link value for jal/jalr.
- valid_d  output  1  IF/ID holds a real fetched instruction.
- fetch_err_d  output  1  see Optional Feature.

Behaviour:
- Reset (reset=0, asynchronous): pc_f=PC_RESET; instr_d=0 (nop); pc_d=PC_RESET; valid_d=0; fetch_err_d=0. Reset mid-operation discards all in-flight state at once.
- im_addr = (pc_f - PC_RESET) >> 2, truncated to IM_AW bits. Combinational. im_rdata is valid in the same cycle.
- Next PC (npc), combinational, 32-bit wrap-around arithmetic:
  - pcsel_d=00: pc_f+4.
  - pcsel_d=01: br_eq_d ? pc_d + 4 + (sext(instr_d[15:0]) << 2) : pc_f+4.
  - pcsel_d=10: {pc_d[31:28], instr_d[25:0], 2'b00}.
  - pcsel_d=11: rs_data_d.
- Whenever valid_d=0, pcsel_d is ignored and npc=pc_f+4.
- Delay slot: the word at pc_f (= pc_d+4) enters IF/ID normally in the redirect cycle. Redirect never flushes IF/ID.
- Per rising edge, priority order:
  - flush=1: instr_d<=0, valid_d<=0, pc_d<=pc_f. PC updates to npc unless stall=1, in which case PC holds.
  - else stall=1: PC, instr_d, pc_d, valid_d all hold. The redirect is not taken; the controller re-presents it next cycle because ID is held.
  - else: pc_f<=npc, instr_d<=im_rdata, pc_d<=pc_f, valid_d<=1.
- pc8_d = pc_d + 8, combinational.
- Latency: one cycle from pc_f to instr_d. Redirect takes effect on pc_f one cycle after the branch is in ID.
- Back-to-back control instructions are handled naturally (branch in a delay slot is undefined by ISA; no special handling).
- pc_f wraps past IM range per im_addr truncation unless the optional check is enabled.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - A fetch is bad if pc_f[1:0]!=0, pc_f < PC_RESET, or pc_f >= PC_RESET + 4*2^IM_AW.
  - On an unstalled, unflushed edge with a bad fetch: instr_d<=0, valid_d<=0, fetch_err_d<=1.
  - fetch_err_d is sticky until reset, and while set pc_f holds its value.
- Not defined: no checks; fetch_err_d is tied 0; pc_f[1:0] is ignored by im_addr.

Test Plan:
- Sequential: reset then 4 cycles, no stall -> pc_f 3000,3004,3008,300C,3010; instr_d follows im_rdata one cycle late; valid_d rises on the first edge.
- Taken beq at 0x3004 with imm=0x0003, br_eq_d=1 -> delay slot 0x3008 enters ID; next pc_f=0x3014.
- Not-taken beq, br_eq_d=0 -> pc_f continues 0x300C.
- jal in ID at pc_d=0x3010, index=0x0000C10 -> pc_f=0x0000_3040; pc8_d=0x3018.
- jr with rs_data_d=0x0000_3100 -> pc_f=0x3100 after the delay slot.
- Stall held 2 cycles during a pending jal -> pc_f and instr_d frozen; redirect taken on the first unstalled edge.
- Flush with stall=1 -> instr_d=0, valid_d=0, pc_f unchanged.
- Reset asserted mid-stream between edges -> outputs return to reset values immediately.
- With FETCH_ALIGN_CHECK_EN, jr to 0x3102 -> fetch_err_d=1, instr_d=0, pc_f stuck at 0x3102.

Source files
------------

// File: rtl/fetch_stage.sv
// IF stage and IF/ID pipeline register of a five-stage MIPS pipeline.
// Optional fetch range/alignment checking is enabled by defining FETCH_ALIGN_CHECK_EN.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int unsigned IM_AW    = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [1:0]       pcsel_d,
  input  logic             br_eq_d,
  input  logic [31:0]      rs_data_d,
  output logic [IM_AW-1:0] im_addr,
  input  logic [31:0]      im_rdata,
  output logic [31:0]      pc_f,
  output logic [31:0]      instr_d,
  output logic [31:0]      pc_d,
  output logic [31:0]      pc8_d,
  output logic             valid_d,
  output logic             fetch_err_d
);

  logic [31:0] pc_q, instr_q, pc_d_q;
  logic        valid_q;
  logic [31:0] npc, seq_pc, br_target;
  logic        bad_fetch;
  logic        hold_pc;

  assign pc_f    = pc_q;
  assign instr_d = instr_q;
  assign pc_d    = pc_d_q;
  assign valid_d = valid_q;
  assign pc8_d   = pc_d_q + 32'd8;

  // Offset from the memory base; low two bits fall away in the shift.
  assign im_addr = IM_AW'((pc_q - PC_RESET) >> 2);

  assign seq_pc    = pc_q + 32'd4;
  assign br_target = pc_d_q + 32'd4 + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

  // Control transfers are resolved from the instruction held in ID.
  always_comb begin
    npc = seq_pc;
    if (valid_q) begin
      case (pcsel_d)
        2'b01:   if (br_eq_d) npc = br_target;
        2'b10:   npc = {pc_d_q[31:28], instr_q[25:0], 2'b00};
        2'b11:   npc = rs_data_d;
        default: npc = seq_pc;
      endcase
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic        err_q;
  logic [32:0] im_end;

  assign im_end    = {1'b0, PC_RESET} + (33'd4 << IM_AW);
  assign bad_fetch = (pc_q[1:0] != 2'b00) || (pc_q < PC_RESET) || ({1'b0, pc_q} >= im_end);
  assign hold_pc   = err_q;
  assign fetch_err_d = err_q;

  // Sticky: once a bad fetch is seen the front end freezes until reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err_q <= 1'b0;
    end else if (!flush && !stall && bad_fetch) begin
      err_q <= 1'b1;
    end
  end
`else
  assign bad_fetch   = 1'b0;
  assign hold_pc     = 1'b0;
  assign fetch_err_d = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q    <= PC_RESET;
      instr_q <= 32'd0;
      pc_d_q  <= PC_RESET;
      valid_q <= 1'b0;
    end else if (flush) begin
      instr_q <= 32'd0;
      valid_q <= 1'b0;
      pc_d_q  <= pc_q;
      if (!stall && !hold_pc) pc_q <= npc;
    end else if (!stall) begin
      pc_d_q <= pc_q;
      if (bad_fetch) begin
        instr_q <= 32'd0;
        valid_q <= 1'b0;
      end else begin
        instr_q <= im_rdata;
        valid_q <= 1'b1;
        if (!hold_pc) pc_q <= npc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; the instruction memory is a bench array.
module tb_fetch_stage;

  localparam int unsigned IM_AW = 10;

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, flush, br_eq_d;
  logic [1:0]       pcsel_d;
  logic [31:0]      rs_data_d;
  logic [IM_AW-1:0] im_addr;
  logic [31:0]      im_rdata;
  logic [31:0]      pc_f, instr_d, pc_d, pc8_d;
  logic             valid_d, fetch_err_d;

  logic [31:0] mem [0:(1<<IM_AW)-1];
  int errors = 0;
  int checks = 0;

  assign im_rdata = mem[im_addr];

  always #5 clk = ~clk;

  fetch_stage #(.PC_RESET(32'h0000_3000), .IM_AW(IM_AW)) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .pcsel_d(pcsel_d),
    .br_eq_d(br_eq_d), .rs_data_d(rs_data_d), .im_addr(im_addr), .im_rdata(im_rdata),
    .pc_f(pc_f), .instr_d(instr_d), .pc_d(pc_d), .pc8_d(pc8_d), .valid_d(valid_d),
    .fetch_err_d(fetch_err_d)
  );

  task automatic do_reset();
    for (int i = 0; i < (1 << IM_AW); i++) mem[i] = 32'h2400_0000 | i;
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pcsel_d = 2'b00; br_eq_d = 1'b0;
    rs_data_d = 32'd0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pcsel_d = 2'b11; br_eq_d = 1'b0;
    rs_data_d = 32'h0000_5000;
    #1;
    checks++;
    if ({pc_f, instr_d, pc_d, pc8_d, valid_d, fetch_err_d, im_addr} !==
        {32'h3000, 32'd0, 32'h3000, 32'h3008, 1'b0, 1'b0, 10'd0}) begin
      errors++;
      $display("FAIL reset_state: got pc_f=%h instr_d=%h pc_d=%h pc8_d=%h v=%b e=%b ia=%h",
               pc_f, instr_d, pc_d, pc8_d, valid_d, fetch_err_d, im_addr);
    end
    for (int i = 0; i < (1 << IM_AW); i++) mem[i] = 32'h2400_0000 | i;
    @(negedge clk);
    reset = 1'b1;
    // pcsel is ignored while ID holds no valid instruction.
    step();
    checks++;
    if ({pc_f, instr_d, valid_d} !== {32'h3004, 32'h2400_0000, 1'b1}) begin
      errors++;
      $display("FAIL invalid_ignores_pcsel: got pc_f=%h instr_d=%h v=%b, expected 3004 24000000 1",
               pc_f, instr_d, valid_d);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_pc;
    do_reset();
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_pc = 32'h3000 + 32'(4 * k);
      checks++;
      if ({pc_f, instr_d, pc_d, valid_d, fetch_err_d} !==
          {exp_pc, 32'h2400_0000 | 32'(k - 1), exp_pc - 32'd4, 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL seq_edge%0d: got pc_f=%h instr_d=%h pc_d=%h v=%b e=%b, expected pc_f=%h",
                 k, pc_f, instr_d, pc_d, valid_d, fetch_err_d, exp_pc);
      end
    end
  endtask

  task automatic test_beq(input logic taken);
    do_reset();
    mem[1] = 32'h1000_0003;
    step();
    step();
    checks++;
    if ({pc_f, instr_d, pc_d} !== {32'h3008, 32'h1000_0003, 32'h3004}) begin
      errors++;
      $display("FAIL beq_in_id: got pc_f=%h instr_d=%h pc_d=%h", pc_f, instr_d, pc_d);
    end
    pcsel_d = 2'b01; br_eq_d = taken;
    step();
    pcsel_d = 2'b00; br_eq_d = 1'b0;
    checks++;
    if ({pc_f, instr_d, pc_d} !== {(taken ? 32'h3014 : 32'h300C), 32'h2400_0002, 32'h3008}) begin
      errors++;
      $display("FAIL beq_redirect taken=%b: got pc_f=%h instr_d=%h pc_d=%h", taken, pc_f,
               instr_d, pc_d);
    end
    step();
    checks++;
    if (instr_d !== (taken ? 32'h2400_0005 : 32'h2400_0003)) begin
      errors++;
      $display("FAIL beq_target_fetch taken=%b: got instr_d=%h", taken, instr_d);
    end
  endtask

  task automatic test_jal(input logic with_stall);
    do_reset();
    mem[4] = 32'h0C00_0C10;
    for (int k = 0; k < 5; k++) step();
    checks++;
    if ({pc_f, instr_d, pc_d, pc8_d} !== {32'h3014, 32'h0C00_0C10, 32'h3010, 32'h3018}) begin
      errors++;
      $display("FAIL jal_in_id: got pc_f=%h instr_d=%h pc_d=%h pc8_d=%h, expected 3014 0c000c10 3010 3018",
               pc_f, instr_d, pc_d, pc8_d);
    end
    pcsel_d = 2'b10;
    if (with_stall) begin
      stall = 1'b1;
      for (int k = 0; k < 2; k++) begin
        step();
        checks++;
        if ({pc_f, instr_d, pc_d, valid_d} !== {32'h3014, 32'h0C00_0C10, 32'h3010, 1'b1}) begin
          errors++;
          $display("FAIL jal_stall%0d: got pc_f=%h instr_d=%h pc_d=%h v=%b", k, pc_f, instr_d,
                   pc_d, valid_d);
        end
      end
      stall = 1'b0;
    end
    step();
    pcsel_d = 2'b00;
    checks++;
    if ({pc_f, instr_d, pc_d} !== {32'h3040, 32'h2400_0005, 32'h3014}) begin
      errors++;
      $display("FAIL jal_redirect stall=%b: got pc_f=%h instr_d=%h pc_d=%h, expected 3040 24000005 3014",
               with_stall, pc_f, instr_d, pc_d);
    end
  endtask

  task automatic test_jr();
    do_reset();
    mem[1] = 32'h03E0_0008;
    step();
    step();
    pcsel_d = 2'b11; rs_data_d = 32'h0000_3100;
    step();
    pcsel_d = 2'b00;
    checks++;
    if ({pc_f, instr_d, pc_d, im_addr} !== {32'h3100, 32'h2400_0002, 32'h3008, 10'h040}) begin
      errors++;
      $display("FAIL jr_redirect: got pc_f=%h instr_d=%h pc_d=%h im_addr=%h", pc_f, instr_d,
               pc_d, im_addr);
    end
    step();
    checks++;
    if ({pc_f, instr_d, pc_d} !== {32'h3104, 32'h2400_0040, 32'h3100}) begin
      errors++;
      $display("FAIL jr_target_fetch: got pc_f=%h instr_d=%h pc_d=%h", pc_f, instr_d, pc_d);
    end
  endtask

  task automatic test_flush();
    do_reset();
    step();
    step();
    flush = 1'b1; stall = 1'b1;
    step();
    checks++;
    if ({pc_f, instr_d, pc_d, valid_d} !== {32'h3008, 32'd0, 32'h3008, 1'b0}) begin
      errors++;
      $display("FAIL flush_stall: got pc_f=%h instr_d=%h pc_d=%h v=%b, expected 3008 0 3008 0",
               pc_f, instr_d, pc_d, valid_d);
    end
    stall = 1'b0;
    step();
    flush = 1'b0;
    checks++;
    if ({pc_f, instr_d, pc_d, valid_d} !== {32'h300C, 32'd0, 32'h3008, 1'b0}) begin
      errors++;
      $display("FAIL flush_nostall: got pc_f=%h instr_d=%h pc_d=%h v=%b, expected 300c 0 3008 0",
               pc_f, instr_d, pc_d, valid_d);
    end
    step();
    checks++;
    if ({pc_f, instr_d, valid_d} !== {32'h3010, 32'h2400_0003, 1'b1}) begin
      errors++;
      $display("FAIL flush_resume: got pc_f=%h instr_d=%h v=%b", pc_f, instr_d, valid_d);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int k = 0; k < 3; k++) step();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({pc_f, instr_d, pc_d, pc8_d, valid_d} !==
        {32'h3000, 32'd0, 32'h3000, 32'h3008, 1'b0}) begin
      errors++;
      $display("FAIL reset_mid: got pc_f=%h instr_d=%h pc_d=%h pc8_d=%h v=%b", pc_f, instr_d,
               pc_d, pc8_d, valid_d);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_misaligned_jr();
    do_reset();
    mem[1] = 32'h03E0_0008;
    step();
    step();
    pcsel_d = 2'b11; rs_data_d = 32'h0000_3102;
    step();
    pcsel_d = 2'b00;
    checks++;
    if ({pc_f, fetch_err_d, im_addr} !== {32'h3102, 1'b0, 10'h040}) begin
      errors++;
      $display("FAIL misaligned_redirect: got pc_f=%h e=%b im_addr=%h", pc_f, fetch_err_d,
               im_addr);
    end
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
`ifdef FETCH_ALIGN_CHECK_EN
      if ({pc_f, instr_d, valid_d, fetch_err_d} !== {32'h3102, 32'd0, 1'b0, 1'b1}) begin
        errors++;
        $display("FAIL align_err%0d: got pc_f=%h instr_d=%h v=%b e=%b, expected 3102 0 0 1", k,
                 pc_f, instr_d, valid_d, fetch_err_d);
      end
`else
      if ({pc_f, instr_d, valid_d, fetch_err_d} !==
          {32'h3106 + 32'(4 * k), 32'h2400_0040 + 32'(k), 1'b1, 1'b0}) begin
        errors++;
        $display("FAIL misaligned_nocheck%0d: got pc_f=%h instr_d=%h v=%b e=%b", k, pc_f,
                 instr_d, valid_d, fetch_err_d);
      end
`endif
    end
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; flush = 1'b0; pcsel_d = 2'b00; br_eq_d = 1'b0;
    rs_data_d = 32'd0;
    test_reset();
    test_sequential();
    test_beq(1'b1);
    test_beq(1'b0);
    test_jal(1'b0);
    test_jal(1'b1);
    test_jr();
    test_flush();
    test_reset_mid();
    test_misaligned_jr();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
